proc_control_fsm: RTL and testbench
===================================

// Module: proc_control_fsm
// PURPOSE
//   Multi-cycle control sequencer for the simple bus-based processor. Latches an instruction
//   {op,rx,ry} on run and steps T1..T3. Drives the register-file enables (rin/rout), the
//   immediate bus driver (dinout), and the ALU controls (ain, gin, gout, addsub).
//   Sits directly upstream of the ALU: it consumes nothing from the datapath and produces every strobe the ALU samples.
// PARAMETERS
//   NREG  8   number of general registers; RW = $clog2(NREG) select bits
//   OPW   3   opcode width; instruction width IW = OPW + 2*RW (9 by default)
// PORTS
//   clk     in   1     system clock, all state on rising edge
//   reset   in   1     synchronous, active-high; clears all state on the next clk edge
//   run     in   1     start request, sampled only in IDLE
//   instr   in   IW    {op[IW-1 -: OPW], rx, ry}, sampled with run
//   rin     out  NREG  one-hot register load enables (0 or 1 bit set)
//   rout    out  NREG  one-hot register bus-drive enables (0 or 1 bit set)
//   dinout  out  1     drive immediate data onto bus
//   ain     out  1     load ALU A register from bus
//   gin     out  1     load ALU G register with A +/- bus
//   gout    out  1     drive G onto bus
//   addsub  out  1     0 = add, 1 = subtract
//   done    out  1     final step of the current instruction
//   busy    out  1     high in every state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, IR=0; all outputs 0 in the cycle after reset is sampled. Reset wins over run.
//   - States: IDLE, T1, T2, T3.
//     - IDLE: if run, IR<=instr and go to T1; otherwise stay.
//   - Outputs are Moore, decoded from state + IR only. instr is never used combinationally.
//   - Opcodes:
//     - 000 mv   Rx<-Ry
//     - 001 mvi  Rx<-D
//     - 010 add  Rx<-Rx+Ry
//     - 011 sub  Rx<-Rx-Ry
//     - 100..111 illegal
//   - mv  T1: rout[ry], rin[rx], done -> IDLE.
//   - mvi T1: dinout, rin[rx], done -> IDLE.
//   - add/sub:
//     - T1: rout[rx], ain.
//     - T2: rout[ry], gin, addsub=(op==sub).
//     - T3: gout, rin[rx], addsub held, done -> IDLE.
//   - illegal T1: done only, no enables asserted -> IDLE.
//   - Latency: run sampled at edge k; T1 occupies cycle k+1. mv/mvi take 1 busy cycle, add/sub take 3.
//   - Back-to-back: the IDLE cycle between instructions is mandatory.
//   - run while busy is ignored (see CONFIGURATION).
//   - rx==ry is legal: the same register is driven in T1 and T2, e.g. add R0,R0 doubles R0.
//   - Exclusivity: at most one bus driver (rout / dinout / gout) active in any cycle.
//   - Reset mid-instruction aborts it: no done pulse, no rin asserted after the reset edge.
// CONFIGURATION
//   CTRL_RUN_QUEUE_EN defined:
//     - A run seen while busy latches instr into a one-deep pending slot.
//     - The pending instruction is loaded into IR in the done cycle's next edge, so T1 follows T-last with no IDLE gap.
//     - Further runs while the slot is full are dropped. Reset clears the slot.
//   Undefined: run while busy ignored; no pending slot logic present.
// STRUCTURE
//   proc_pkg: opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB) and the state encoding (S_IDLE..S_T3).
//   Sub-module reg_sel_decoder #(NREG): RW-bit index -> NREG-bit one-hot with enable.
//   Instantiated twice, once for rin and once for rout.
// TESTING
//   1. reset=1 for 2 cycles, run=1 -> all outputs 0, busy=0, no T1 entered.
//   2. instr=9'b001_010_000, run pulse -> next cycle dinout=1, rin=8'h04, done=1; following cycle busy=0.
//   3. instr=9'b010_001_011 -> T1: rout=8'h02, ain=1.
//      T2: rout=8'h08, gin=1, addsub=0.
//      T3: gout=1, rin=8'h02, done=1.
//   4. instr=9'b011_000_000 -> T2: rout=8'h01, gin=1, addsub=1.
//      T3: rin=8'h01, addsub=1, done=1.
//   5. Hold run=1 through an add, assert reset during T2 -> next cycle all outputs 0, IDLE.
//      Illegal 9'b111_000_000 -> T1: done=1, rin=rout=0.
//   6. (CTRL_RUN_QUEUE_EN) run add then pulse run with mvi during T2 -> mvi T1 immediately follows add T3.
//      Without the macro -> the mvi is ignored.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode and state definitions for the processor control sequencer.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot enable decoder; all zeros when not enabled.
module reg_sel_decoder #(
  parameter int NREG = 8,
  localparam int RW = $clog2(NREG)
) (
  input  logic            en,
  input  logic [RW-1:0]   idx,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control sequencer: latches {op,rx,ry} on run and steps T1..T3.
// Optional one-deep pending-instruction slot enabled by defining CTRL_RUN_QUEUE_EN.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int NREG = 8,
  parameter int OPW  = 3,
  localparam int RW  = $clog2(NREG),
  localparam int IW  = OPW + 2*RW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [IW-1:0]   instr,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            dinout,
  output logic            ain,
  output logic            gin,
  output logic            gout,
  output logic            addsub,
  output logic            done,
  output logic            busy
);

  state_t        state, state_next;
  logic [IW-1:0] ir, ir_next;
  logic [OPW-1:0] op;
  logic [RW-1:0]  rx, ry;
  logic           is_sub;
  logic           rin_en, rout_en;
  logic [RW-1:0]  rin_idx, rout_idx;

  assign op     = ir[IW-1 -: OPW];
  assign rx     = ir[2*RW-1 -: RW];
  assign ry     = ir[RW-1:0];
  assign is_sub = (op == OP_SUB);
  assign busy   = (state != S_IDLE);

`ifdef CTRL_RUN_QUEUE_EN
  logic          pend_valid, pend_valid_next;
  logic [IW-1:0] pend_instr, pend_instr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_instr <= '0;
    end else begin
      pend_valid <= pend_valid_next;
      pend_instr <= pend_instr_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    ir_next    = ir;
    rin_en     = 1'b0;
    rin_idx    = rx;
    rout_en    = 1'b0;
    rout_idx   = ry;
    dinout     = 1'b0;
    ain        = 1'b0;
    gin        = 1'b0;
    gout       = 1'b0;
    addsub     = 1'b0;
    done       = 1'b0;
`ifdef CTRL_RUN_QUEUE_EN
    pend_valid_next = pend_valid;
    pend_instr_next = pend_instr;
`endif

    unique case (state)
      S_IDLE: begin
        if (run) begin
          ir_next    = instr;
          state_next = S_T1;
        end
      end
      S_T1: begin
        case (op)
          OP_MV: begin
            rout_en  = 1'b1;
            rout_idx = ry;
            rin_en   = 1'b1;
            rin_idx  = rx;
            done     = 1'b1;
          end
          OP_MVI: begin
            dinout  = 1'b1;
            rin_en  = 1'b1;
            rin_idx = rx;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_en    = 1'b1;
            rout_idx   = rx;
            ain        = 1'b1;
            state_next = S_T2;
          end
          default: done = 1'b1;
        endcase
      end
      S_T2: begin
        rout_en    = 1'b1;
        rout_idx   = ry;
        gin        = 1'b1;
        addsub     = is_sub;
        state_next = S_T3;
      end
      S_T3: begin
        gout    = 1'b1;
        rin_en  = 1'b1;
        rin_idx = rx;
        addsub  = is_sub;
        done    = 1'b1;
      end
    endcase

    if (done) state_next = S_IDLE;

`ifdef CTRL_RUN_QUEUE_EN
    // A run arriving in the done cycle itself chains straight into T1 rather than parking in the slot.
    if (busy && run && !pend_valid) begin
      pend_valid_next = 1'b1;
      pend_instr_next = instr;
    end
    if (done) begin
      if (pend_valid) begin
        ir_next         = pend_instr;
        state_next      = S_T1;
        pend_valid_next = 1'b0;
      end else if (run) begin
        ir_next         = instr;
        state_next      = S_T1;
        pend_valid_next = 1'b0;
      end
    end
`endif
  end

  reg_sel_decoder #(.NREG(NREG)) u_rin_dec (
    .en     (rin_en),
    .idx    (rin_idx),
    .onehot (rin)
  );

  reg_sel_decoder #(.NREG(NREG)) u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (rout)
  );

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm; expectations follow CTRL_RUN_QUEUE_EN when defined.
module tb_proc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [8:0] instr = '0;
  logic [7:0] rin, rout;
  logic       dinout, ain, gin, gout, addsub, done, busy;

  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic       done;
    logic       busy;
  } outs_t;

  typedef struct {
    int    stamp;
    string tag;
    outs_t v;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  localparam outs_t IDLE_O = '0;

  proc_control_fsm #(.NREG(8), .OPW(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .instr  (instr),
    .rin    (rin),
    .rout   (rout),
    .dinout (dinout),
    .ain    (ain),
    .gin    (gin),
    .gout   (gout),
    .addsub (addsub),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic outs_t mk(input logic [7:0] r_in, input logic [7:0] r_out,
                               input logic d, input logic a, input logic gi,
                               input logic go, input logic as, input logic dn);
    outs_t o;
    o.rin = r_in; o.rout = r_out; o.dinout = d; o.ain = a; o.gin = gi;
    o.gout = go; o.addsub = as; o.done = dn; o.busy = 1'b1;
    return o;
  endfunction

  task automatic expect_at(input int stamp, input string tag, input outs_t v);
    item_t it;
    it.stamp = stamp; it.tag = tag; it.v = v;
    sb.push_back(it);
  endtask

  // Inputs change on the falling edge, so each call covers exactly one rising edge.
  task automatic applyStimulus(input logic rst, input logic r, input logic [8:0] ins);
    reset = rst;
    run   = r;
    instr = ins;
    @(negedge clk);
  endtask

  task automatic checkOutput(input item_t it);
    outs_t act;
    act = {rin, rout, dinout, ain, gin, gout, addsub, done, busy};
    checks++;
    if (act !== it.v) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got rin=%h rout=%h din=%b ain=%b gin=%b gout=%b as=%b done=%b busy=%b, want rin=%h rout=%h din=%b ain=%b gin=%b gout=%b as=%b done=%b busy=%b",
               it.tag, cyc, act.rin, act.rout, act.dinout, act.ain, act.gin, act.gout,
               act.addsub, act.done, act.busy, it.v.rin, it.v.rout, it.v.dinout, it.v.ain,
               it.v.gin, it.v.gout, it.v.addsub, it.v.done, it.v.busy);
    end
  endtask

  // Monitor: pops whichever expectation is stamped for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: expectation for cyc %0d never checked (now %0d)", sb[0].tag, sb[0].stamp, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].stamp == cyc) checkOutput(sb.pop_front());
  end

  initial begin
    int b;
    @(negedge clk);

    // Reset held with run high must keep everything idle.
    b = cyc;
    expect_at(b+1, "reset1", IDLE_O);
    expect_at(b+2, "reset2", IDLE_O);
    expect_at(b+3, "post_reset", IDLE_O);
    applyStimulus(1'b1, 1'b1, 9'b010_001_011);
    applyStimulus(1'b1, 1'b1, 9'b010_001_011);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // mvi R2
    b = cyc;
    expect_at(b+1, "mvi_t1", mk(8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    expect_at(b+2, "mvi_idle", IDLE_O);
    applyStimulus(1'b0, 1'b1, 9'b001_010_000);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // add R1,R3
    b = cyc;
    expect_at(b+1, "add_t1", mk(8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    expect_at(b+2, "add_t2", mk(8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    expect_at(b+3, "add_t3", mk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(b+4, "add_idle", IDLE_O);
    applyStimulus(1'b0, 1'b1, 9'b010_001_011);
    repeat (3) applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // sub R0,R0: same register drives in T1 and T2
    b = cyc;
    expect_at(b+1, "sub_t1", mk(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    expect_at(b+2, "sub_t2", mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    expect_at(b+3, "sub_t3", mk(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    expect_at(b+4, "sub_idle", IDLE_O);
    applyStimulus(1'b0, 1'b1, 9'b011_000_000);
    repeat (3) applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // run held through an add, reset during T2 aborts it
    b = cyc;
    expect_at(b+1, "abort_t1", mk(8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    expect_at(b+2, "abort_t2", mk(8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    expect_at(b+3, "abort_reset", IDLE_O);
    expect_at(b+4, "abort_after", IDLE_O);
    applyStimulus(1'b0, 1'b1, 9'b010_001_011);
    applyStimulus(1'b0, 1'b1, 9'b010_001_011);
    applyStimulus(1'b1, 1'b1, 9'b010_001_011);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // illegal opcode: done only
    b = cyc;
    expect_at(b+1, "illegal_t1", mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    expect_at(b+2, "illegal_idle", IDLE_O);
    applyStimulus(1'b0, 1'b1, 9'b111_000_000);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // mv R3,R5 with run held two edges
    b = cyc;
    expect_at(b+1, "mv_t1", mk(8'h08, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`ifdef CTRL_RUN_QUEUE_EN
    expect_at(b+2, "mv_chain", mk(8'h08, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`else
    expect_at(b+2, "mv_gap", IDLE_O);
`endif
    expect_at(b+3, "mv_idle", IDLE_O);
    applyStimulus(1'b0, 1'b1, 9'b000_011_101);
    applyStimulus(1'b0, 1'b1, 9'b000_011_101);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // add, then mvi pulsed during T2
    b = cyc;
    expect_at(b+1, "q_add_t1", mk(8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    expect_at(b+2, "q_add_t2", mk(8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    expect_at(b+3, "q_add_t3", mk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
`ifdef CTRL_RUN_QUEUE_EN
    expect_at(b+4, "q_mvi_t1", mk(8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`else
    expect_at(b+4, "q_mvi_ignored", IDLE_O);
`endif
    expect_at(b+5, "q_idle", IDLE_O);
    applyStimulus(1'b0, 1'b1, 9'b010_001_011);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);
    applyStimulus(1'b0, 1'b1, 9'b001_010_000);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);
    applyStimulus(1'b0, 1'b0, 9'b000_000_000);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
